// File: rtl/clint_timer_if.sv
// Data-bus port of the machine timer: request/write channel from the requester,
// read data and completion pulse back from the timer.
interface clint_timer_if;
  logic        I_req;
  logic        I_we;
  logic [31:0] I_addr;
  logic [31:0] I_wdata;
  logic [3:0]  I_mask;
  logic [31:0] O_rdata;
  logic        O_ready;

  modport master (
    output I_req, I_we, I_addr, I_wdata, I_mask,
    input  O_rdata, O_ready
  );

  modport slave (
    input  I_req, I_we, I_addr, I_wdata, I_mask,
    output O_rdata, O_ready
  );
endinterface

// File: rtl/clint_timer.sv
// Memory-mapped machine timer: free-running 64-bit mtime with prescaler,
// 64-bit mtimecmp and level interrupt, served over a one-cycle-ready dbus port.
module clint_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic         clk,
  input  logic         rst,
  clint_timer_if.slave bus,
  output logic         O_timer_int
);

  typedef enum logic {IDLE, RESP} state_t;

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  // Word offsets (byte offset >> 2)
  localparam logic [13:0] W_CTRL   = 14'h0000;
  localparam logic [13:0] W_CMP_LO = 14'h1000;
  localparam logic [13:0] W_CMP_HI = 14'h1001;
  localparam logic [13:0] W_MT_LO  = 14'h2FFE;
  localparam logic [13:0] W_MT_HI  = 14'h2FFF;

  state_t      state;
  logic        ready_q;
  logic [31:0] rdata_q;
  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        en;
  logic [15:0] presc;
  logic        timer_int_q;

  logic        hit;
  logic [13:0] word;
  logic        accept;
  logic        wr;
  logic        tick;
  logic [31:0] rd_val;
  logic        unused_addr;

  assign unused_addr = ^bus.I_addr[1:0];

  assign hit    = (bus.I_addr[31:16] == BASE_ADDR[31:16]);
  assign word   = bus.I_addr[15:2];
  assign accept = (state == IDLE) && bus.I_req;
  assign wr     = accept && bus.I_we && hit;
  assign tick   = en && (presc == PRESC_MAX);

  function automatic logic [31:0] merge(input logic [31:0] old_val,
                                        input logic [31:0] wdata,
                                        input logic [3:0]  mask);
    logic [31:0] r;
    r = old_val;
    for (int unsigned i = 0; i < 4; i++)
      if (mask[i]) r[8*i +: 8] = wdata[8*i +: 8];
    return r;
  endfunction

  always_comb begin
    rd_val = '0;
    if (hit) begin
      case (word)
        W_CTRL:   rd_val = {31'b0, en};
        W_CMP_LO: rd_val = mtimecmp[31:0];
        W_CMP_HI: rd_val = mtimecmp[63:32];
        W_MT_LO:  rd_val = mtime[31:0];
        W_MT_HI:  rd_val = mtime[63:32];
        default:  rd_val = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      mtime       <= '0;
      mtimecmp    <= '1;
      en          <= 1'b1;
      presc       <= '0;
      timer_int_q <= 1'b0;
    end else begin
      timer_int_q <= (mtime >= mtimecmp);

      if (tick)    presc <= '0;
      else if (en) presc <= presc + 16'd1;

      // A bus write to either mtime half suppresses the tick increment of both halves
      if (wr && word == W_MT_LO)
        mtime[31:0] <= merge(mtime[31:0], bus.I_wdata, bus.I_mask);
      else if (wr && word == W_MT_HI)
        mtime[63:32] <= merge(mtime[63:32], bus.I_wdata, bus.I_mask);
      else if (tick)
        mtime <= mtime + 64'd1;

      if (wr && word == W_CMP_LO)
        mtimecmp[31:0] <= merge(mtimecmp[31:0], bus.I_wdata, bus.I_mask);
      if (wr && word == W_CMP_HI)
        mtimecmp[63:32] <= merge(mtimecmp[63:32], bus.I_wdata, bus.I_mask);
      if (wr && word == W_CTRL && bus.I_mask[0])
        en <= bus.I_wdata[0];

      case (state)
        IDLE: begin
          ready_q <= accept;
          if (accept) begin
            state <= RESP;
            if (!bus.I_we) rdata_q <= rd_val;
          end
        end
        RESP: begin
          ready_q <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.O_ready = ready_q;
  assign bus.O_rdata = rdata_q;
  assign O_timer_int = timer_int_q;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: directed scenarios plus random bus traffic, checked by
// a scoreboard fed from a behavioural model of the timer's register rules.
module tb_clint_timer;
  localparam int unsigned P    = 4;
  localparam logic [31:0] BASE = 32'h0200_0000;

  logic clk = 1'b0;
  logic rst;
  logic timer_int;
  always #5 clk = ~clk;

  clint_timer_if bus();

  clint_timer #(.BASE_ADDR(BASE), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .bus(bus), .O_timer_int(timer_int)
  );

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;
  bit started = 1'b0;

  // Behavioural model: mtime advances once per P enabled cycles
  longint unsigned m_mtime, m_cmp, m_ecount;
  bit m_en, m_int, m_ready, m_busy;

  function automatic logic [31:0] apply_mask(input logic [31:0] o, input logic [31:0] w,
                                             input logic [3:0] m);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = m[i] ? w[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a[31:16] != BASE[31:16]) return 32'h0;
    case ({a[15:2], 2'b00})
      16'h0000: return {31'b0, m_en};
      16'h4000: return m_cmp[31:0];
      16'h4004: return m_cmp[63:32];
      16'hBFF8: return m_mtime[31:0];
      16'hBFFC: return m_mtime[63:32];
      default:  return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    bit acc, tick, n_int, n_en;
    longint unsigned nm, nc;
    logic [31:0] a;
    logic [15:0] off;
    if (rst) begin
      m_mtime = 0; m_cmp = 64'hFFFF_FFFF_FFFF_FFFF; m_ecount = 0;
      m_en = 1; m_int = 0; m_ready = 0; m_busy = 0;
      q.delete();
    end else begin
      acc   = bus.I_req && !m_busy;
      tick  = m_en && ((m_ecount % P) == P - 1);
      n_int = (m_mtime >= m_cmp);
      nm    = tick ? m_mtime + 64'd1 : m_mtime;
      nc    = m_cmp;
      n_en  = m_en;
      if (acc) begin
        a = bus.I_addr;
        q.push_back('{bus.I_we, a, model_read(a)});
        if (bus.I_we && a[31:16] == BASE[31:16]) begin
          off = {a[15:2], 2'b00};
          case (off)
            16'h0000: if (bus.I_mask[0]) n_en = bus.I_wdata[0];
            16'h4000: nc[31:0]  = apply_mask(m_cmp[31:0],  bus.I_wdata, bus.I_mask);
            16'h4004: nc[63:32] = apply_mask(m_cmp[63:32], bus.I_wdata, bus.I_mask);
            16'hBFF8: nm = {m_mtime[63:32], apply_mask(m_mtime[31:0], bus.I_wdata, bus.I_mask)};
            16'hBFFC: nm = {apply_mask(m_mtime[63:32], bus.I_wdata, bus.I_mask), m_mtime[31:0]};
            default: ;
          endcase
        end
      end
      if (m_en) m_ecount = m_ecount + 1;
      m_mtime = nm; m_cmp = nc; m_en = n_en; m_int = n_int;
      m_busy = acc; m_ready = acc;
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Monitor / scoreboard
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (started) begin
      checks++;
      if (bus.O_ready !== m_ready) begin
        errors++;
        $display("FAIL ready: got %b want %b at %0t", bus.O_ready, m_ready, $time);
      end
      checks++;
      if (timer_int !== m_int) begin
        errors++;
        $display("FAIL timer_int: got %b want %b at %0t", timer_int, m_int, $time);
      end
      if (bus.O_ready === 1'b1 && m_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL scoreboard: response with empty queue at %0t", $time);
        end else begin
          e = q.pop_front();
          if (!e.we) begin
            checks++;
            if (bus.O_rdata !== e.data) begin
              errors++;
              $display("FAIL rdata @%h: got %h want %h at %0t", e.addr, bus.O_rdata, e.data, $time);
            end
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic xfer(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] m, output logic [31:0] rd);
    bit got;
    got = 0;
    rd = '0;
    bus.I_we = we; bus.I_addr = addr; bus.I_wdata = wd; bus.I_mask = m; bus.I_req = 1'b1;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (bus.O_ready === 1'b1) begin
        got = 1;
        rd = bus.O_rdata;
      end
    end
    bus.I_req = 1'b0;
    if (!got) begin
      checks++; errors++;
      $display("FAIL timeout @%h: got no ready want ready", addr);
    end
  endtask

  task automatic wr(input logic [15:0] off, input logic [31:0] d, input logic [3:0] m = 4'hF);
    logic [31:0] dummy;
    xfer(1'b1, {BASE[31:16], off}, d, m, dummy);
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] v);
    xfer(1'b0, addr, 32'h0, 4'h0, v);
  endtask

  initial begin
    logic [31:0] v, snap;
    logic [31:0] raddrs[7];
    bit found;
    int idx;
    raddrs = '{BASE | 32'h0000, BASE | 32'h4000, BASE | 32'h4004, BASE | 32'hBFF8,
               BASE | 32'hBFFC, BASE | 32'h1234, 32'h0300_BFF8};

    bus.I_req = 0; bus.I_we = 0; bus.I_addr = '0; bus.I_wdata = '0; bus.I_mask = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    started = 1'b1;
    rst = 1'b0;

    // Reset release
    check("rst_rdata", {32'h0, bus.O_rdata}, 64'h0);
    rd(BASE | 32'hBFF8, v);  check("rst_mtime_lo", {32'h0, v}, 64'h0);
    check("rst_int", {63'h0, timer_int}, 64'h0);
    rd(BASE | 32'h4004, v);  check("rst_cmp_hi", {32'h0, v}, 64'hFFFF_FFFF);
    rd(BASE | 32'h0000, v);  check("rst_ctrl", {32'h0, v}, 64'h1);

    // Prescaled counting, then freeze
    repeat (40) @(negedge clk);
    rd(BASE | 32'hBFF8, v);
    wr(16'h0000, 32'h0);
    snap = m_mtime[31:0];
    repeat (20) @(negedge clk);
    rd(BASE | 32'hBFF8, v);  check("frozen_mtime", {32'h0, v}, {32'h0, snap});
    wr(16'h0000, 32'h1);

    // Interrupt assert / deassert
    wr(16'h4004, 32'h0);
    wr(16'h4000, 32'd100);
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      if (m_mtime >= 100) found = 1;
      else @(negedge clk);
    end
    check("reach_100", {63'h0, found}, 64'h1);
    repeat (2) @(negedge clk);
    check("int_high", {63'h0, timer_int}, 64'h1);
    wr(16'h4000, 32'hFFFF_FFFF);
    @(negedge clk);
    check("int_low", {63'h0, timer_int}, 64'h0);

    // Carry from low to high word
    wr(16'hBFFC, 32'h0);
    wr(16'hBFF8, 32'hFFFF_FFFF);
    repeat (10) @(negedge clk);
    rd(BASE | 32'hBFFC, v);  check("carry_hi", {32'h0, v}, 64'h1);

    // Byte mask
    wr(16'h4000, 32'h1122_3344);
    wr(16'h4000, 32'hAABB_CCDD, 4'b0101);
    rd(BASE | 32'h4000, v);  check("mask_cmp_lo", {32'h0, v}, 64'h11BB_33DD);

    // Collision: write mtime on a tick edge
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (!m_busy && m_en && (m_ecount % P) == P - 1) found = 1;
    end
    check("tick_align", {63'h0, found}, 64'h1);
    wr(16'hBFF8, 32'd5);
    rd(BASE | 32'hBFF8, v);  check("collision", {32'h0, v}, 64'd5);

    // Unmapped offset and foreign base
    rd(BASE | 32'h1234, v);  check("unmapped", {32'h0, v}, 64'h0);
    rd(32'h0300_BFF8, v);    check("foreign_base", {32'h0, v}, 64'h0);

    // 64-bit wrap with mtimecmp at max
    wr(16'h4000, 32'hFFFF_FFFF);
    wr(16'h4004, 32'hFFFF_FFFF);
    wr(16'hBFFC, 32'hFFFF_FFFF);
    wr(16'hBFF8, 32'hFFFF_FFFD);
    repeat (20) @(negedge clk);
    rd(BASE | 32'hBFFC, v);  check("wrap_hi", {32'h0, v}, 64'h0);

    // Random traffic
    for (int n = 0; n < 250; n++) begin
      idx = $urandom_range(0, 6);
      if ($urandom_range(0, 1) == 1) begin
        v = $urandom;
        if (idx == 0) v[0] = ($urandom_range(0, 3) != 0);
        xfer(1'b1, raddrs[idx] | 32'($urandom_range(0, 3)), v, 4'($urandom_range(0, 15)), snap);
      end else begin
        rd(raddrs[idx], v);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset during RESP
    repeat (2) @(negedge clk);
    bus.I_we = 1; bus.I_addr = BASE | 32'h4000; bus.I_wdata = 32'h0; bus.I_mask = 4'hF;
    bus.I_req = 1'b1;
    @(negedge clk);
    check("pre_rst_ready", {63'h0, bus.O_ready}, 64'h1);
    rst = 1'b1;
    bus.I_req = 1'b0;
    @(negedge clk);
    check("rst_resp_ready", {63'h0, bus.O_ready}, 64'h0);
    check("rst_resp_rdata", {32'h0, bus.O_rdata}, 64'h0);
    rst = 1'b0;
    rd(BASE | 32'hBFF8, v);  check("rst2_mtime_lo", {32'h0, v}, 64'h0);
    rd(BASE | 32'hBFFC, v);  check("rst2_mtime_hi", {32'h0, v}, 64'h0);
    rd(BASE | 32'h4000, v);  check("rst2_cmp_lo", {32'h0, v}, 64'hFFFF_FFFF);
    rd(BASE | 32'h4004, v);  check("rst2_cmp_hi", {32'h0, v}, 64'hFFFF_FFFF);
    rd(BASE | 32'h0000, v);  check("rst2_ctrl", {32'h0, v}, 64'h1);

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
# clint_timer

Memory-mapped machine timer that sits on the core's data bus, downstream of `riscv_ic`'s dbus port. It holds a free-running 64-bit `mtime`, a 64-bit `mtimecmp` and a control register, and answers dbus reads and writes with a one-cycle ready handshake. It produces `timer_int`, which feeds bit 0 of the core's `I_int` vector in `top`.

## Interface
- `BASE_ADDR`, default 32'h0200_0000: block base address. Decode compares `I_addr[31:16]` against `BASE_ADDR[31:16]`.
- `PRESCALE`, default 1: clock cycles per `mtime` tick. Legal range 1..65535.
- `clk`  in  1  system clock; the single clock.
- `rst`  in  1  synchronous, active-high reset.
- `I_req`  in  1  bus request. Held by the requester until `O_ready`.
- `I_we`  in  1  1 = write, 0 = read.
- `I_addr`  in  32  byte address. Bits [1:0] are ignored.
- `I_wdata`  in  32  write data.
- `I_mask`  in  4  byte-lane write enables. Bit n enables byte n.
- `O_rdata`  out  32  read data. Valid only while `O_ready`=1.
- `O_ready`  out  1  one-cycle completion pulse.
- `O_timer_int`  out  1  machine timer interrupt, level-sensitive.

## Operation
- Register map (offset = `I_addr[15:0]`):
  - 0x0000 CTRL: bit0 = EN. Other bits read 0.
  - 0x4000 MTIMECMP_LO.
  - 0x4004 MTIMECMP_HI.
  - 0xBFF8 MTIME_LO.
  - 0xBFFC MTIME_HI.
- Unmapped offsets, and addresses whose `[31:16]` do not match the base:
  - reads return 0 and writes are ignored;
  - the request still completes with `O_ready`.
- Bus FSM has two states:
  - IDLE: if `I_req`=1, accept the request and go to RESP.
  - RESP: `O_ready`=1; `I_req` is ignored; return to IDLE unconditionally.
- Acceptance edge:
  - Writes update every byte whose `I_mask` bit is set; unmasked bytes hold.
  - Reads capture the addressed register's value from before that edge into `O_rdata`.
- Prescaler:
  - The counter runs 0..PRESCALE-1 while EN=1 and holds while EN=0.
  - `tick`=1 when the counter equals PRESCALE-1 and EN=1. The counter wraps to 0 on that cycle.
- `mtime` increments by 1 on each tick, modulo 2^64. The carry from the low word propagates to the high word in the same cycle.
- Collision: if a write to MTIME_LO or MTIME_HI is accepted on a tick edge:
  - the write wins;
  - `mtime` does not increment that cycle (neither half);
  - the prescaler still wraps.
- `O_timer_int` is a register: next value = (`mtime` >= `mtimecmp`), a 64-bit unsigned compare of the current register values.
- Writing CTRL.EN=0 freezes `mtime` and the prescaler. `O_timer_int` keeps tracking the compare.

## Timing
- Reset values:
  - `mtime`=0.
  - `mtimecmp`=64'hFFFF_FFFF_FFFF_FFFF.
  - EN=1.
  - Prescaler=0.
  - FSM=IDLE.
  - `O_ready`=0, `O_rdata`=0, `O_timer_int`=0.
- Latency: `I_req` high at edge N gives `O_ready`=1 for the cycle after edge N. Throughput is at most one transaction every 2 cycles.
- Requester protocol: drop `I_req` in the cycle it sees `O_ready`=1. A request still high in the following IDLE cycle is treated as a new transaction.
- `O_rdata` holds its value outside RESP.
- Interrupt timing: `O_timer_int` changes one cycle after the `mtime`/`mtimecmp` update that causes it.
  - Example: a write making `mtimecmp` <= `mtime` is accepted at edge N; `O_timer_int` rises at edge N+1.
- Reset in RESP: at the reset edge `O_ready` goes to 0 and any pending response is dropped. A write accepted before reset is overwritten by the reset values.
- Wrap: when `mtime`=2^64-1 and a tick occurs, `mtime` becomes 0.
  - With `mtimecmp`=2^64-1, `O_timer_int` is 1 before the wrap and falls one cycle after it.

## Test plan
- Reset release, PRESCALE=1:
  - read MTIME_LO at first IDLE -> `O_ready` one cycle later, `O_rdata`=0;
  - `O_timer_int`=0; read MTIMECMP_HI -> 32'hFFFF_FFFF.
- PRESCALE=4, run 40 cycles then read MTIME_LO -> value = floor(elapsed cycles/4). Then write CTRL=0, wait 20 cycles, reread -> value +0.
- Interrupt assert/deassert:
  - write MTIMECMP_HI=0 and MTIMECMP_LO=100 -> `O_timer_int` rises exactly one cycle after `mtime` reaches 100;
  - write MTIMECMP_LO=32'hFFFF_FFFF -> `O_timer_int` falls one cycle after that write.
- Write MTIME_LO=32'hFFFF_FFFF and MTIME_HI=0, then tick -> MTIME_HI reads 1, MTIME_LO reads 0.
- Byte mask and collision:
  - MTIMECMP_LO=32'h1122_3344, then write 32'hAABB_CCDD with `I_mask`=4'b0101 -> readback 32'h11BB_33DD;
  - write MTIME_LO=5 on a tick edge -> reads back 5, not 6.
- Read offset 0x1234 -> `O_rdata`=0, `O_ready` pulses.
- Assert `rst` during RESP -> `O_ready`=0 at the next edge, and all registers read their reset values.
